uart_rx_sipo: RTL and testbench
===============================

Name: uart_rx_sipo

Overview:
UART receive path, the counterpart of the team's PISO transmitter. Samples the asynchronous serial line at CLKS_PER_BIT system clocks per bit. Frame format is 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). Deserialises each frame into a parallel word, flags framing errors and presents one-cycle valid strobes to the downstream consumer.

Parameters:
CLKS_PER_BIT, 16, system clocks per serial bit; must be >= 4.
DATA_BITS, 8, data bits per frame; data_out width.

Ports:
Clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
rx_in  input  1  asynchronous serial line, idle high.
data_out  output  DATA_BITS  last correctly received word.
data_valid  output  1  one-cycle pulse: data_out just updated.
framing_error  output  1  one-cycle pulse: stop bit sampled as 0.
busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Interface: reset is asynchronous, active-high; clock is Clk.
- Reset values: data_out=0, data_valid=0, framing_error=0, busy=0, state=IDLE, counters=0, shift register=0. Both synchroniser flops reset to 1 so the line reads idle.
- Synchroniser: rx_in passes through 2 flops (rx_sync). All decisions use rx_sync, which is rx_in delayed by 2 cycles.
- Bit counter: bit_cnt, width clog2(CLKS_PER_BIT). Index counter: idx, 0..DATA_BITS-1.
- IDLE:
  - rx_sync==0 -> START, bit_cnt=0.
- START (mid-bit check):
  - Increment bit_cnt until bit_cnt==CLKS_PER_BIT/2-1.
  - At that count, rx_sync==0 -> DATA, bit_cnt=0, idx=0.
  - At that count, rx_sync==1 -> glitch; return to IDLE with no output pulse.
- DATA:
  - Increment bit_cnt. At bit_cnt==CLKS_PER_BIT-1, sample rx_sync into the shift register, shifting right with the new bit entering at the MSB. This makes the first-received bit land at bit 0.
  - At the same count, reset bit_cnt and increment idx.
  - After the sample with idx==DATA_BITS-1 -> STOP.
- STOP:
  - At bit_cnt==CLKS_PER_BIT-1, sample rx_sync.
  - rx_sync==1: next cycle data_out=shift register, data_valid=1 for exactly 1 cycle, state -> IDLE.
  - rx_sync==0: framing_error=1 for exactly 1 cycle, data_out unchanged, state -> BREAK.
- BREAK:
  - Stay until rx_sync==1, then -> IDLE. This prevents a held-low line (break) from retriggering frames.
- Sampling point: every sample falls ~mid-bit, one bit period after the previous sample. Latency from rx_in rising into the stop-bit centre to data_valid is <= CLKS_PER_BIT/2+3 cycles.
- Back-to-back frames: IDLE accepts a new start edge on the cycle after returning from STOP. No idle gap is required beyond the stop bit.
- data_valid and framing_error are never high in the same cycle. Neither is high in IDLE except on the transition cycle out of STOP.
- Reset mid-frame: immediately returns to IDLE with all outputs at reset values. The partial word is discarded and there are no pulses after release.
- rx_in changes during DATA between sample points have no effect.

Test Plan:
- All tests use CLKS_PER_BIT=16 and DATA_BITS=8.
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), 16 clocks/bit -> one data_valid pulse, data_out=8'hA5, framing_error never high, busy drops after STOP.
- Glitch: rx_in low for 4 clocks then high -> stays/returns to IDLE; no data_valid, no framing_error, data_out unchanged.
- Framing error: frame 0x3C with stop bit driven 0 and held low 40 clocks -> one framing_error pulse, data_out keeps previous value (0x00 after reset), busy stays high until the line returns high, then IDLE.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three data_valid pulses exactly 160 clocks apart, data_out 0x00, 0xFF, 0x81 in order.
- Reset mid-frame: assert reset during data bit 4 of 0x55, release, then send 0x96 -> no pulse for 0x55, one data_valid with data_out=8'h96.
- Baud tolerance: send 0x5A with bit periods of 15 and 17 clocks (±6%) -> data_out=8'h5A, no framing_error in both cases.

Source files
------------

// File: rtl/uart_rx_sipo.sv
// ============================================================================
//  Module   : uart_rx_sipo
//  Brief    : UART receiver. 2-flop synchroniser, mid-bit sampling, framing
//             error detection and break hold-off.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sipo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_rx_meta     <= rx_in;
            r_rx_sync     <= r_rx_meta;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state   <= S_START;
                        r_bit_cnt <= '0;
                    end
                end

                // Re-check the start bit at its centre to reject short glitches
                S_START: begin
                    if (r_bit_cnt == c_half_last) begin
                        r_bit_cnt <= '0;
                        r_idx     <= '0;
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                end

                // LSB arrives first, so shift right with new bits at the MSB
                S_DATA: begin
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_idx_last) begin
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + c_idx_one;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_rx_sync) begin
                            data_out   <= r_shift;
                            data_valid <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            r_state       <= S_BREAK;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                end

                // Hold off until the line returns high so a break is one error
                S_BREAK: begin
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
// ============================================================================
//  Module   : tb_uart_rx_sipo
//  Brief    : Directed self-checking bench for uart_rx_sipo.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_sipo;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          Clk   = 1'b0;
    logic          reset = 1'b1;
    logic          rx_in = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          framing_error;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;
    logic [DB-1:0] vdata [64];
    int            vcyc  [64];

    uart_rx_sipo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Pulse recorder: every high cycle counts, so a stretched pulse shows up
    always @(negedge Clk) begin
        if (data_valid) begin
            if (n_valid < 64) begin
                vdata[n_valid] = data_out;
                vcyc[n_valid]  = cyc;
            end
            n_valid++;
        end
        if (framing_error) n_ferr++;
        if (data_valid && framing_error) n_both++;
    end

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Bit j of the frame (0 = start) lasts t_even clocks for even j, else t_odd
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int t_even, input int t_odd, input int t_stop);
        drive_bit(1'b0, t_even);
        for (int i = 0; i < DB; i++)
            drive_bit(d[i], ((i + 1) % 2 == 0) ? t_even : t_odd);
        drive_bit(stop_v, t_stop);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        idle(10);
    endtask

    task automatic test_framing_error;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive_bit(8'h3C >> i, CPB);
        drive_bit(1'b0, 20);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses expected 1", n_ferr - f0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
        drive_bit(1'b0, 20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold: got %b expected 1", busy); end
        idle(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_single: got %0d pulses expected 1", n_ferr - f0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d pulses expected 0", n_valid - v0); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL ferr_data_kept: got %h expected 00", data_out); end
        idle(10);
    endtask

    task automatic test_single_frame;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, CPB, CPB, CPB);
        idle(4);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - v0); end
        checks++; if (vdata[v0] !== 8'hA5) begin errors++; $display("FAIL single_strobe_data: got %h expected a5", vdata[v0]); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data_out: got %h expected a5", data_out); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_no_ferr: got %0d expected 0", n_ferr - f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        drive_bit(1'b0, 4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        idle(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b expected 0", busy); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", n_valid - v0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected 0", n_ferr - f0); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data_kept: got %h expected a5", data_out); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_frame(8'h00, 1'b1, CPB, CPB, CPB);
        send_frame(8'hFF, 1'b1, CPB, CPB, CPB);
        send_frame(8'h81, 1'b1, CPB, CPB, CPB);
        idle(8);
        checks++; if (n_valid - v0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n_valid - v0); end
        checks++; if (vdata[v0] !== 8'h00) begin errors++; $display("FAIL b2b_word0: got %h expected 00", vdata[v0]); end
        checks++; if (vdata[v0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_word1: got %h expected ff", vdata[v0+1]); end
        checks++; if (vdata[v0+2] !== 8'h81) begin errors++; $display("FAIL b2b_word2: got %h expected 81", vdata[v0+2]); end
        checks++; if (vcyc[v0+1] - vcyc[v0] !== 160) begin errors++; $display("FAIL b2b_gap01: got %0d expected 160", vcyc[v0+1] - vcyc[v0]); end
        checks++; if (vcyc[v0+2] - vcyc[v0+1] !== 160) begin errors++; $display("FAIL b2b_gap12: got %0d expected 160", vcyc[v0+2] - vcyc[v0+1]); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(8'h55 >> i, CPB);
        drive_bit(1'b1, 8);
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data_out: got %h expected 00", data_out); end
        reset = 1'b0;
        idle(200);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d expected 0", n_valid - v0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rst_mid_no_ferr: got %0d expected 0", n_ferr - f0); end
        send_frame(8'h96, 1'b1, CPB, CPB, CPB);
        idle(8);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rst_mid_valid_count: got %0d expected 1", n_valid - v0); end
        checks++; if (data_out !== 8'h96) begin errors++; $display("FAIL rst_mid_data: got %h expected 96", data_out); end
    endtask

    // Bit periods alternate 15/17 clocks: each bit is 6% off nominal
    task automatic test_baud_tolerance;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h5A, 1'b1, 15, 17, 17);
        idle(8);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL baud_a_valid: got %0d expected 1", n_valid - v0); end
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL baud_a_data: got %h expected 5a", data_out); end
        send_frame(8'h5A, 1'b1, 17, 15, 15);
        idle(8);
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL baud_b_valid: got %0d expected 2", n_valid - v0); end
        checks++; if (vdata[v0+1] !== 8'h5A) begin errors++; $display("FAIL baud_b_data: got %h expected 5a", vdata[v0+1]); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL baud_no_ferr: got %0d expected 0", n_ferr - f0); end
    endtask

    initial begin
        test_reset;
        test_framing_error;
        test_single_frame;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        test_baud_tolerance;
        checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_and_ferr_overlap: got %0d cycles expected 0", n_both); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
